// File: rtl/cache_pkg.sv
// Shared types for the write-back buffer: widths, drain states and
// the entry record held in each FIFO slot.
package cache_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;

  typedef enum logic {
    IDLE,
    WRITE
  } drain_st_e;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wbb_entry_t;

endpackage

// File: rtl/wbb_match.sv
// Address match across the buffer window, oldest to youngest,
// so the last hit in the scan is the youngest entry.
module wbb_match
  import cache_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  wbb_entry_t        ents_i [DEPTH],
  input  logic [PW-1:0]     head_i,
  input  logic [PW-1:0]     tail_i,
  output logic              hit_o,
  output logic [PW-1:0]     idx_o,
  output logic [DATA_W-1:0] data_o
);

  logic [PW-1:0] idx;
  logic          past;

  always_comb begin
    hit_o  = 1'b0;
    idx_o  = head_i;
    data_o = '0;
    idx    = head_i;
    past   = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PW'(k);
      // reaching tail again ends the occupied window
      if (k != 0 && idx == tail_i) past = 1'b1;
      if (!past && ents_i[idx].valid &&
          ents_i[idx].addr == addr_i) begin
        hit_o  = 1'b1;
        idx_o  = idx;
        data_o = ents_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/write_back_buffer.sv
// Posted-write buffer: coalescing FIFO of evicted words drained
// to main memory, with a registered lookup for read fills.
module write_back_buffer
  import cache_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              rd_lookup,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_hit,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_req,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              empty,
  output logic [CW-1:0]     count
);

  wbb_entry_t        ents_q [DEPTH];
  wbb_entry_t        ents_d [DEPTH];
  wbb_entry_t        coal_ents [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  drain_st_e         state_q, state_d;
  logic              wb_ready_q, wb_ready_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              rd_hit_q, rd_hit_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic              coal_hit, lk_hit;
  logic [PW-1:0]     coal_idx, lk_idx;
  logic [DATA_W-1:0] coal_data, lk_data;
  logic              push, alloc, coal, pop, launch;
  logic              unused_match;

  // the in-flight head must never absorb a newer write
  always_comb begin
    coal_ents = ents_q;
    if (state_q == WRITE) coal_ents[head_q].valid = 1'b0;
  end

  wbb_match #(.DEPTH(DEPTH)) u_coal (
    .addr_i (wb_addr),
    .ents_i (coal_ents),
    .head_i (head_q),
    .tail_i (tail_q),
    .hit_o  (coal_hit),
    .idx_o  (coal_idx),
    .data_o (coal_data)
  );

  wbb_match #(.DEPTH(DEPTH)) u_look (
    .addr_i (rd_addr),
    .ents_i (ents_q),
    .head_i (head_q),
    .tail_i (tail_q),
    .hit_o  (lk_hit),
    .idx_o  (lk_idx),
    .data_o (lk_data)
  );

  assign unused_match = ^{lk_idx, coal_data};

  assign push   = wb_valid & wb_ready_q;
  assign coal   = push & coal_hit;
  assign alloc  = push & ~coal_hit;
  assign pop    = (state_q == WRITE) & mem_ready;
  assign launch = (state_q == IDLE) & (count_q != '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (launch) state_d = WRITE;
      WRITE:   if (mem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ents_d = ents_q;
    if (coal) ents_d[coal_idx].data = wb_data;
    if (pop) ents_d[head_q].valid = 1'b0;
    if (alloc) ents_d[tail_q] = '{1'b1, wb_addr, wb_data};
    head_d  = pop ? head_q + PW'(1) : head_q;
    tail_d  = alloc ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(alloc) - CW'(pop);
    wb_ready_d = (count_d != CW'(DEPTH));
  end

  // launch reads the post-coalesce head so a same-edge update is kept
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (launch) begin
      mem_addr_d  = ents_q[head_q].addr;
      mem_wdata_d = ents_d[head_q].data;
    end
    rd_hit_d  = rd_lookup & lk_hit;
    rd_data_d = rd_hit_d ? lk_data : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ents_q[i] <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      wb_ready_q  <= 1'b1;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_hit_q    <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      ents_q      <= ents_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      state_q     <= state_d;
      wb_ready_q  <= wb_ready_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_hit_q    <= rd_hit_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign wb_ready  = wb_ready_q;
  assign mem_req   = (state_q == WRITE);
  assign mem_wen   = (state_q == WRITE);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rd_hit    = rd_hit_q;
  assign rd_data   = rd_data_q;
  assign count     = count_q;
  assign empty     = (count_q == '0) && (state_q == IDLE);

endmodule

// File: tb/tb_write_back_buffer.sv
// Randomized bench for write_back_buffer against a queue model.
module tb_write_back_buffer;
  localparam int DEPTH = 4;
  localparam int AW = 14;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_valid, wb_ready;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          rd_lookup, rd_hit;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          mem_req, mem_wen, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          empty;
  logic [2:0]    count;

  write_back_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_ready(wb_ready),
    .rd_lookup(rd_lookup), .rd_addr(rd_addr),
    .rd_hit(rd_hit), .rd_data(rd_data),
    .mem_req(mem_req), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  bit            infl, m_rdy, e_hit;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d, e_rdata;
  int            n_vec, n_err;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    infl  = 0;
    m_rdy = 1;
    e_hit = 0;
  endtask

  task automatic check_all();
    chk("count", 64'(count), 64'(q.size()));
    chk("mem_req", 64'(mem_req), 64'(infl));
    chk("mem_wen", 64'(mem_wen), 64'(infl));
    chk("wb_ready", 64'(wb_ready), 64'(m_rdy));
    chk("empty", 64'(empty), 64'(q.size() == 0 && !infl));
    chk("rd_hit", 64'(rd_hit), 64'(e_hit));
    if (e_hit) chk("rd_data", 64'(rd_data), 64'(e_rdata));
    if (infl) begin
      chk("mem_addr", 64'(mem_addr), 64'(m_a));
      chk("mem_wdata", 64'(mem_wdata), 64'(m_d));
    end
  endtask

  // drive one cycle, advance the model across the edge, then check
  task automatic cyc(bit v, logic [AW-1:0] a, logic [DW-1:0] d,
                     bit lk, logic [AW-1:0] ra, bit mr);
    bit push, pop, launch;
    int j;
    wb_valid = v; wb_addr = a; wb_data = d;
    rd_lookup = lk; rd_addr = ra; mem_ready = mr;
    e_hit = 0; e_rdata = '0;
    if (lk)
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].a == ra) begin
          e_hit = 1; e_rdata = q[i].d; break;
        end
    push   = v && m_rdy;
    pop    = infl && mr;
    launch = !infl && q.size() > 0;
    j = -1;
    if (push)
      for (int i = infl ? 1 : 0; i < q.size(); i++)
        if (q[i].a == a) j = i;
    if (push && j >= 0) q[j].d = d;
    if (launch) begin
      m_a = q[0].a; m_d = q[0].d; infl = 1;
    end
    if (pop) begin
      void'(q.pop_front());
      infl = 0;
    end
    if (push && j < 0) q.push_back('{a: a, d: d});
    m_rdy = (q.size() != DEPTH);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(int n, bit mr);
    for (int i = 0; i < n; i++) cyc(0, '0, '0, 0, '0, mr);
  endtask

  initial begin
    int acc;
    n_vec = 0; n_err = 0;
    wb_valid = 0; wb_addr = '0; wb_data = '0;
    rd_lookup = 0; rd_addr = '0; mem_ready = 0;
    rst = 1;
    #1 rst = 0;
    #2;
    model_reset();
    check_all();
    chk("rst_mem_addr", 64'(mem_addr), 64'h0);
    chk("rst_rd_data", 64'(rd_data), 64'h0);
    @(negedge clk);
    rst = 1;

    // single push held, lookups, then drain
    cyc(1, 14'h400, 32'hAAAAAAAA, 0, '0, 0);
    idle(2, 0);
    cyc(0, '0, '0, 1, 14'h400, 0);
    cyc(0, '0, '0, 1, 14'h404, 0);
    idle(1, 1);
    idle(1, 0);
    cyc(0, '0, '0, 1, 14'h400, 0);
    idle(1, 0);

    // fill to full, fifth push refused, then drain in order
    cyc(1, 14'h440, 32'h1, 0, '0, 0);
    cyc(1, 14'h480, 32'h2, 0, '0, 0);
    cyc(1, 14'h4C0, 32'h3, 0, '0, 0);
    cyc(1, 14'h500, 32'h4, 0, '0, 0);
    cyc(1, 14'h540, 32'h5, 0, '0, 0);
    chk("full_count", 64'(count), 64'd4);
    idle(12, 1);

    // coalesce behind an in-flight head; re-push of head allocates
    cyc(1, 14'h440, 32'h10, 0, '0, 0);
    cyc(1, 14'h480, 32'h11111111, 0, '0, 0);
    cyc(1, 14'h480, 32'h22222222, 0, '0, 0);
    chk("coal_count", 64'(count), 64'd2);
    cyc(1, 14'h440, 32'h33, 1, 14'h440, 0);
    chk("head_realloc", 64'(count), 64'd3);
    idle(10, 1);

    // wrap-around with push and pop together
    acc = 0;
    for (int c = 0; c < 200 && acc < 10; c++) begin
      bit ok;
      ok = m_rdy;
      cyc(1, 14'h600 + 14'(acc), $urandom, 0, '0, 1);
      if (ok) acc++;
    end
    chk("wrap_accepted", 64'(acc), 64'd10);
    idle(24, 1);

    // random traffic over a small address pool
    for (int c = 0; c < 600; c++)
      cyc($urandom_range(0, 9) < 6, 14'h700 + 14'($urandom_range(0, 5)),
          $urandom, $urandom_range(0, 1) == 1,
          14'h700 + 14'($urandom_range(0, 6)), $urandom_range(0, 1) == 1);
    idle(20, 1);

    // reset while a write is in flight with three entries held
    cyc(1, 14'h100, 32'hA, 0, '0, 0);
    cyc(1, 14'h104, 32'hB, 0, '0, 0);
    cyc(1, 14'h108, 32'hC, 0, '0, 0);
    chk("pre_rst_count", 64'(count), 64'd3);
    chk("pre_rst_req", 64'(mem_req), 64'd1);
    #2 rst = 0;
    #1;
    chk("async_req", 64'(mem_req), 64'd0);
    chk("async_count", 64'(count), 64'd0);
    chk("async_ready", 64'(wb_ready), 64'd1);
    model_reset();
    @(negedge clk);
    rst = 1;
    idle(6, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
